// File: rtl/pixel_scan_sequencer.sv
// pixel_scan_sequencer: streams a framebuffer to a WS2812B serializer in linear or serpentine order, then holds the latch gap.
module pixel_scan_sequencer #(
    parameter int ROW_DIM      = 8,
    parameter int COL_DIM      = 8,
    parameter int LATCH_CYCLES = 6000,
    parameter int SERPENTINE   = 1,
    localparam int N  = ROW_DIM * COL_DIM,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          fb_rd_en,
    output logic [IW-1:0] fb_addr,
    input  logic [23:0]   fb_rd_data,
    output logic [23:0]   pix_data,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          busy,
    output logic          frame_done
);
    localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [LW-1:0] LATCH_INIT = LW'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_WAIT, ST_SEND, ST_LATCH} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [LW-1:0] lcnt, lcnt_nxt;
    logic [23:0]   pix_nxt;
    logic [31:0]   row, col, col_m;

    assign fb_rd_en   = state == ST_FETCH;
    assign pix_valid  = state == ST_SEND;
    assign busy       = state != ST_IDLE;
    assign frame_done = state == ST_LATCH && lcnt == '0;

    // 32-bit intermediates keep row*COL_DIM exact for any matrix shape
    always_comb begin
        row     = 32'(idx) / 32'(COL_DIM);
        col     = 32'(idx) % 32'(COL_DIM);
        col_m   = (SERPENTINE != 0 && row[0]) ? 32'(COL_DIM) - 32'd1 - col : col;
        fb_addr = IW'(row * 32'(COL_DIM) + col_m);
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        lcnt_nxt  = lcnt;
        pix_nxt   = pix_data;
        case (state)
            ST_IDLE: begin
                state_nxt = start ? ST_FETCH : ST_IDLE;
                idx_nxt   = start ? '0 : idx;
            end
            ST_FETCH: state_nxt = ST_WAIT;
            ST_WAIT: begin
                state_nxt = ST_SEND;
                pix_nxt   = fb_rd_data;
            end
            ST_SEND: if (pix_ready) begin
                state_nxt = (idx == IDX_LAST) ? ST_LATCH : ST_FETCH;
                idx_nxt   = (idx == IDX_LAST) ? idx : idx + 1'b1;
                lcnt_nxt  = (idx == IDX_LAST) ? LATCH_INIT : lcnt;
            end
            ST_LATCH: begin
                state_nxt = (lcnt == '0) ? ST_IDLE : ST_LATCH;
                lcnt_nxt  = (lcnt == '0) ? lcnt : lcnt - 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            lcnt     <= '0;
            pix_data <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            lcnt     <= lcnt_nxt;
            pix_data <= pix_nxt;
        end
endmodule

// File: doc/pixel_scan_sequencer.md
PIXEL_SCAN_SEQUENCER -- requirements
Module: pixel_scan_sequencer

Interface
REQ-001 SHALL have parameter ROW_DIM, default 8, number of matrix rows (>=1, any integer).
REQ-002 SHALL have parameter COL_DIM, default 8, number of matrix columns (>=1, any integer).
REQ-003 SHALL have parameter LATCH_CYCLES, default 6000, idle cycles after last pixel (>=1).
REQ-004 SHALL have parameter SERPENTINE, default 1, 1 = reverse column order on odd rows, 0 = linear.
REQ-005 SHALL have local width IW = $clog2(ROW_DIM*COL_DIM), minimum 1.
REQ-006 clk  input  1  single clock, all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  frame request, sampled only in IDLE.
REQ-009 fb_rd_en  output  1  framebuffer read strobe.
REQ-010 fb_addr  output  IW  physical framebuffer address.
REQ-011 fb_rd_data  input  24  GRB word, valid the cycle after fb_rd_en (1-cycle RAM latency).
REQ-012 pix_data  output  24  pixel word to the WS2812B serializer.
REQ-013 pix_valid  output  1  pix_data valid.
REQ-014 pix_ready  input  1  serializer accepts pix_data.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 frame_done  output  1  one-cycle pulse at end of LATCH.

Function
REQ-017 SHALL implement states IDLE, FETCH, WAIT, SEND, LATCH in registered encoding.
REQ-018 IDLE: start=1 -> FETCH, logical index idx <= 0; start=0 -> stay.
REQ-019 FETCH: fb_rd_en=1 for exactly this cycle; next state WAIT.
REQ-020 WAIT: pix_data <= fb_rd_data at end of cycle; next state SEND.
REQ-021 SEND: pix_valid=1; pix_data SHALL stay stable until handshake (pix_valid & pix_ready).
REQ-022 SEND handshake with idx < N-1 (N=ROW_DIM*COL_DIM): idx <= idx+1, -> FETCH; with idx = N-1: -> LATCH, latch counter <= LATCH_CYCLES-1.
REQ-023 SEND without handshake: stay, no change to idx or pix_data.
REQ-024 LATCH: counter decrements each cycle; at counter = 0 -> IDLE with frame_done=1 in that final LATCH cycle.
REQ-025 fb_addr SHALL equal map(idx) combinationally from registered idx: row = idx / COL_DIM, col = idx % COL_DIM, col' = COL_DIM-1-col if SERPENTINE=1 and row odd, else col; addr = row*COL_DIM + col'.
REQ-026 Mapping SHALL be exact for non-power-of-two ROW_DIM/COL_DIM; no truncation of intermediate row*COL_DIM.
REQ-027 fb_addr value outside FETCH is don't-care; fb_rd_en SHALL be 0 outside FETCH.
REQ-028 start asserted while busy=1 (including the frame_done cycle) SHALL be ignored, not queued.
REQ-029 Latency: start sampled high at edge of cycle 0 -> fb_rd_en in cycle 1, pix_valid earliest in cycle 3; with pix_ready held 1, one pixel per 3 cycles.
REQ-030 ROW_DIM*COL_DIM = 1: single FETCH/WAIT/SEND then LATCH.
REQ-031 pix_ready while pix_valid=0 SHALL have no effect.

Reset
REQ-032 rst_n=0 SHALL immediately (asynchronously) force state IDLE, idx 0, latch counter 0, pix_data 0, pix_valid 0, fb_rd_en 0, busy 0, frame_done 0.
REQ-033 Reset mid-frame SHALL abort the frame with no frame_done; first frame after release starts at idx 0 only on a new start.
REQ-034 Outputs SHALL remain at reset values until the first rising clk edge after rst_n deasserts.

Verification
REQ-035 ROW_DIM=3, COL_DIM=4, SERPENTINE=1, pix_ready=1, start pulse -> fb_addr sequence 0,1,2,3,7,6,5,4,8,9,10,11, 12 handshakes, then frame_done once.
REQ-036 Same config, SERPENTINE=0 -> fb_addr sequence 0..11 ascending.
REQ-037 RAM model returns data = addr; pix_ready toggled randomly -> pix_data stable while pix_valid & !pix_ready, accepted words equal mapped address sequence, no drop or duplicate.
REQ-038 LATCH_CYCLES=5 -> exactly 5 cycles in LATCH after last handshake, frame_done high in 5th, busy low next cycle; start pulses during frame and in frame_done cycle ignored.
REQ-039 Start at cycle 0 with pix_ready=1 -> fb_rd_en in cycle 1, pix_valid in cycle 3, next fb_rd_en in cycle 4.
REQ-040 rst_n pulsed low during SEND of pixel 5 -> all outputs reset asynchronously, no frame_done; new start fetches addr 0 first.
